mpu6050_poll_sequencer: RTL and testbench

Autonomous, parametrised register sequencer that sits between top level and i2c_master. It replaces manual one-register-at-a-time selection.
- After enable, performs an optional init write (wake the device), then periodically sweeps NUM_REGS consecutive registers starting at BASE_REG.
- Each sweep is captured into a shadow bank and published atomically to a readable snapshot bank.
- Timeouts, sweep counting and a sample-valid strobe are provided for downstream logic.

---
 rtl/mpu6050_poll_sequencer_if.sv | 22 ++
 rtl/mpu6050_poll_sequencer.sv | 158 +++++++++++++++
 tb/tb_mpu6050_poll_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu6050_poll_sequencer_if.sv
// rtl/mpu6050_poll_sequencer_if.sv - transaction handshake between the poll sequencer and i2c_master
interface mpu6050_poll_sequencer_if;
    logic       i2c_start;
    logic [6:0] ext_slave_address_in;
    logic       ext_read_write_in;
    logic [7:0] ext_register_address_in;
    logic [7:0] ext_data_in;
    logic       i2c_done;
    logic [7:0] ext_data_out;

    modport master (
        output i2c_start, ext_slave_address_in, ext_read_write_in,
               ext_register_address_in, ext_data_in,
        input  i2c_done, ext_data_out
    );

    modport slave (
        input  i2c_start, ext_slave_address_in, ext_read_write_in,
               ext_register_address_in, ext_data_in,
        output i2c_done, ext_data_out
    );
endinterface

// File: rtl/mpu6050_poll_sequencer.sv
// rtl/mpu6050_poll_sequencer.sv - periodic register sweep with atomic snapshot publish
module mpu6050_poll_sequencer #(
    parameter logic [6:0] SLAVE_ADDRESS  = 7'h69,
    parameter logic [7:0] BASE_REG       = 8'h41,
    parameter int         NUM_REGS       = 8,
    parameter bit         INIT_EN        = 1'b1,
    parameter logic [7:0] INIT_REG       = 8'h6B,
    parameter logic [7:0] INIT_DATA      = 8'h00,
    parameter int         POLL_DIV       = 100000,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    mpu6050_poll_sequencer_if.master         bus,
    input  logic [5:0]                       rd_index,
    output logic [7:0]                       rd_data,
    output logic                             sample_valid,
    output logic [15:0]                      sweep_count,
    output logic                             timeout_err,
    output logic                             busy
);
    localparam int             TW         = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int             CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TICK_LAST  = TW'(POLL_DIV - 1);
    localparam logic [CW-1:0]  TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]     IDX_LAST   = 6'(NUM_REGS - 1);
    localparam logic [6:0]     NUM_REGS_W = 7'(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE, INIT_START, INIT_WAIT, WAIT_TICK, RD_START, RD_WAIT, PUBLISH
    } state_t;

    state_t          state, next_state;
    logic [5:0]      idx, next_idx;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   tocnt;
    logic            init_done, init_pending;
    logic            sweep_start, in_wait, timed_out, tick;
    logic [6:0]      addr_q;
    logic            rw_q;
    logic [7:0]      reg_q, data_q;
    // Banks span the full rd_index range; entries at or above NUM_REGS stay zero.
    logic [7:0]      shadow   [64];
    logic [7:0]      snapshot [64];

    always_comb begin
        next_state   = state;
        next_idx     = idx;
        sweep_start  = 1'b0;
        in_wait      = (state == INIT_WAIT) || (state == RD_WAIT);
        timed_out    = in_wait && !bus.i2c_done && (tocnt == TO_LAST);
        tick         = (timer >= TICK_LAST);
        init_pending = INIT_EN && !init_done;
        case (state)
            IDLE: if (en) begin
                sweep_start = 1'b1;
                next_state  = init_pending ? INIT_START : RD_START;
            end
            INIT_START: next_state = INIT_WAIT;
            INIT_WAIT: begin
                if (bus.i2c_done) begin
                    if (!en) next_state = IDLE;
                    else begin
                        next_state  = RD_START;
                        sweep_start = 1'b1;
                    end
                end else if (timed_out) begin
                    next_state = en ? WAIT_TICK : IDLE;
                end
            end
            WAIT_TICK: begin
                if (!en) next_state = IDLE;
                else if (tick) begin
                    sweep_start = 1'b1;
                    next_state  = init_pending ? INIT_START : RD_START;
                end
            end
            RD_START: next_state = RD_WAIT;
            RD_WAIT: begin
                // A stopped or timed-out sweep is dropped; idx restarts at the next sweep.
                if (bus.i2c_done) begin
                    if (!en) next_state = IDLE;
                    else if (idx == IDX_LAST) next_state = PUBLISH;
                    else begin
                        next_state = RD_START;
                        next_idx   = idx + 6'd1;
                    end
                end else if (timed_out) begin
                    next_state = en ? WAIT_TICK : IDLE;
                end
            end
            PUBLISH: next_state = WAIT_TICK;
            default: next_state = IDLE;
        endcase
        if (sweep_start) next_idx = 6'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= 6'd0;
            timer       <= '0;
            tocnt       <= '0;
            init_done   <= 1'b0;
            timeout_err <= 1'b0;
            sweep_count <= 16'd0;
            addr_q      <= 7'd0;
            rw_q        <= 1'b0;
            reg_q       <= 8'd0;
            data_q      <= 8'd0;
            rd_data     <= 8'd0;
            for (int i = 0; i < 64; i++) begin
                shadow[i]   <= 8'd0;
                snapshot[i] <= 8'd0;
            end
        end else begin
            state <= next_state;
            idx   <= next_idx;
            if (sweep_start) timer <= '0;
            else if (state != IDLE && !tick) timer <= timer + 1'b1;
            if (state == INIT_START || state == RD_START) tocnt <= '0;
            else if (in_wait && tocnt != TO_LAST) tocnt <= tocnt + 1'b1;
            if (timed_out) timeout_err <= 1'b1;
            if (state == INIT_WAIT && bus.i2c_done) init_done <= 1'b1;
            if (state == RD_WAIT && bus.i2c_done) shadow[idx] <= bus.ext_data_out;
            if (state == PUBLISH) begin
                for (int i = 0; i < 64; i++) snapshot[i] <= shadow[i];
                sweep_count <= sweep_count + 16'd1;
            end
            // Request fields are loaded on entry to a start state and held until the next one.
            if (next_state == INIT_START) begin
                addr_q <= SLAVE_ADDRESS;
                rw_q   <= 1'b0;
                reg_q  <= INIT_REG;
                data_q <= INIT_DATA;
            end else if (next_state == RD_START) begin
                addr_q <= SLAVE_ADDRESS;
                rw_q   <= 1'b1;
                reg_q  <= BASE_REG + {2'b00, next_idx};
                data_q <= 8'd0;
            end
            // Bypass from shadow so a read in the publish cycle already sees the new sweep.
            if ({1'b0, rd_index} < NUM_REGS_W)
                rd_data <= (state == PUBLISH) ? shadow[rd_index] : snapshot[rd_index];
            else
                rd_data <= 8'd0;
        end
    end

    assign bus.i2c_start               = (state == INIT_START) || (state == RD_START);
    assign bus.ext_slave_address_in    = addr_q;
    assign bus.ext_read_write_in       = rw_q;
    assign bus.ext_register_address_in = reg_q;
    assign bus.ext_data_in             = data_q;
    assign sample_valid                = (state == PUBLISH);
    assign busy                        = (state != IDLE);
endmodule

// File: tb/tb_mpu6050_poll_sequencer.sv
// tb/tb_mpu6050_poll_sequencer.sv - bench for mpu6050_poll_sequencer
module tb_mpu6050_poll_sequencer;
    localparam int TO  = 50;
    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [5:0]  rd_index;
    logic [7:0]  rd_data;
    logic        sample_valid;
    logic [15:0] sweep_count;
    logic        timeout_err;
    logic        busy;

    mpu6050_poll_sequencer_if bus ();

    mpu6050_poll_sequencer #(.POLL_DIV(200), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .bus(bus.master),
        .rd_index(rd_index), .rd_data(rd_data), .sample_valid(sample_valid),
        .sweep_count(sweep_count), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int c; logic rw; logic [7:0] rg; logic [7:0] dt; } txn_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    txn_t start_log[$];
    int   done_log[$];
    int   sv_log[$];
    int   sv_cnt    = 0;
    int   terr_cyc  = -1;
    int   drop_cyc  = -1;
    logic [7:0] salt = 8'h00;
    bit   drop_armed = 0;
    bit   model_on   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: answers every request LAT cycles after i2c_start; can swallow one 0x43 read.
    bit         s_pend = 0, s_drop = 0, s_dropped = 0;
    int         s_wcnt = 0;
    logic       s_rw;
    logic [7:0] s_reg;
    initial begin bus.i2c_done = 1'b0; bus.ext_data_out = 8'h00; end
    always @(posedge clk) begin
        #2;
        bus.i2c_done     = 1'b0;
        bus.ext_data_out = 8'h00;
        if (!rst) s_pend = 0;
        else if (s_pend) begin
            s_wcnt--;
            if (s_wcnt == 0) begin
                s_pend = 0;
                if (!s_drop) begin
                    bus.i2c_done     = 1'b1;
                    bus.ext_data_out = s_rw ? (8'hA0 + (s_reg - 8'h41) + salt) : 8'h00;
                    done_log.push_back(cyc);
                end
            end
        end
        if (bus.i2c_start) begin
            s_pend = 1;
            s_wcnt = LAT;
            s_rw   = bus.ext_read_write_in;
            s_reg  = bus.ext_register_address_in;
            start_log.push_back('{cyc, s_rw, s_reg, bus.ext_data_in});
            s_drop = drop_armed && !s_dropped && s_rw && s_reg == 8'h43;
            if (s_drop) begin s_dropped = 1; drop_cyc = cyc; end
        end
    end

    // Transaction-level reference: which request comes next, what each sweep publishes.
    logic [7:0]  m_snap [8];
    logic [7:0]  m_shadow [8];
    bit          m_initp = 1, m_pend = 0, m_pub = 0, m_terr = 0;
    int          m_k = 0, m_age = 0;
    logic        m_erw;
    logic [7:0]  m_ereg;
    logic [15:0] m_count = 16'd0;
    logic [7:0]  m_rd = 8'h00;
    initial for (int i = 0; i < 8; i++) begin m_snap[i] = 8'h00; m_shadow[i] = 8'h00; end

    always @(negedge clk) if (model_on) begin
        bit pub_next, started;
        pub_next = 0;
        started  = 0;
        chk("sample_valid", sample_valid, m_pub);
        chk("sweep_count", sweep_count, m_count);
        chk("timeout_err", timeout_err, m_terr);
        chk("rd_data", rd_data, m_rd);
        if (sample_valid) begin sv_cnt++; sv_log.push_back(cyc); end
        if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
        if (bus.i2c_start) begin
            started = 1;
            chk("start_overlap", m_pend, 0);
            m_erw  = !m_initp;
            m_ereg = m_initp ? 8'h6B : 8'h41 + 8'(m_k);
            m_pend = 1;
            m_age  = 0;
        end
        if (m_pend) begin
            chk("ext_addr", bus.ext_slave_address_in, 7'h69);
            chk("ext_rw", bus.ext_read_write_in, m_erw);
            chk("ext_reg", bus.ext_register_address_in, m_ereg);
            chk("ext_data", bus.ext_data_in, 8'h00);
            chk("busy_in_txn", busy, 1);
        end
        if (!rst) begin
            m_initp = 1; m_pend = 0; m_terr = 0; m_k = 0; m_count = 16'd0; m_rd = 8'h00;
            for (int i = 0; i < 8; i++) m_snap[i] = 8'h00;
        end else begin
            if (m_pub) begin
                for (int i = 0; i < 8; i++) m_snap[i] = m_shadow[i];
                m_count++;
            end
            if (m_pend && !started) begin
                m_age++;
                if (bus.i2c_done) begin
                    m_pend = 0;
                    if (!m_erw) begin
                        m_initp = 0;
                        m_k     = 0;
                    end else begin
                        m_shadow[m_k] = bus.ext_data_out;
                        if (!en) m_k = 0;
                        else if (m_k == 7) begin pub_next = 1; m_k = 0; end
                        else m_k++;
                    end
                end else if (m_age == TO) begin
                    m_pend = 0;
                    m_terr = 1;
                    m_k    = 0;
                end
            end
            m_rd = (rd_index < 6'd8) ? m_snap[rd_index[2:0]] : 8'h00;
        end
        m_pub = pub_next;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic nwait();
        @(negedge clk); #1;
    endtask

    task automatic wait_sv(input int target, input int budget, input string name);
        int n = 0;
        while (sv_cnt < target && n < budget) begin nwait(); n++; end
        chk(name, (sv_cnt >= target), 1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int n = 0;
        while (start_log.size() < target && n < budget) begin nwait(); n++; end
        chk(name, (start_log.size() >= target), 1);
    endtask

    task automatic wait_reg(input logic [7:0] rg, input int budget, input string name);
        int n = 0;
        while ((start_log.size() == 0 || start_log[$].rg != rg) && n < budget) begin nwait(); n++; end
        chk(name, (n < budget), 1);
    endtask

    task automatic rd_chk(input int k, input logic [7:0] exp, input string name);
        tick();
        rd_index = 6'(k);
        @(posedge clk);
        nwait();
        chk(name, rd_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int ns, nd, di, n;
        int c41[$];
        rst = 1'b0; en = 1'b0; rd_index = 6'd0;
        @(posedge clk); #1;
        model_on = 1;
        tick(); tick();
        nwait();
        chk("rst_start", bus.i2c_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", sweep_count, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_addr", bus.ext_slave_address_in, 0);
        chk("rst_reg", bus.ext_register_address_in, 0);
        chk("rst_rd", rd_data, 0);

        // First sweep after wake-up write
        tick();
        rst = 1'b1; en = 1'b1;
        wait_sv(1, 500, "first_publish");
        if (start_log.size() < 9) chk("seq_len", start_log.size(), 9);
        else begin
            chk("init_rw", start_log[0].rw, 0);
            chk("init_reg", start_log[0].rg, 8'h6B);
            chk("init_data", start_log[0].dt, 8'h00);
            for (int k = 1; k <= 8; k++) begin
                chk("seq_rw", start_log[k].rw, 1);
                chk("seq_reg", start_log[k].rg, 8'h41 + 8'(k - 1));
            end
        end
        if (done_log.size() >= 9 && sv_log.size() >= 1)
            chk("publish_after_8th_done", sv_log[0], done_log[8] + 1);
        else chk("done_len", done_log.size(), 9);
        nwait();
        chk("count_after_first", sweep_count, 1);
        for (int k = 0; k < 8; k++) rd_chk(k, 8'hA0 + 8'(k), "readout");
        rd_chk(9, 8'h00, "readout_oob");

        // Sweep period
        wait_sv(4, 1500, "four_sweeps");
        foreach (start_log[i]) if (start_log[i].rw && start_log[i].rg == 8'h41) c41.push_back(start_log[i].c);
        chk("sweep_starts_enough", (c41.size() >= 4), 1);
        for (int i = 1; i < c41.size(); i++) chk("sweep_period", c41[i] - c41[i-1], 200);

        // Dropped third read
        tick();
        salt = 8'h10; drop_armed = 1;
        n = 0;
        while (terr_cyc < 0 && n < 600) begin nwait(); n++; end
        chk("timeout_seen", (terr_cyc >= 0), 1);
        chk("timeout_latency", terr_cyc - drop_cyc, TO + 1);
        rd_chk(0, 8'hA0, "snapshot_kept_after_timeout");
        di = -1;
        foreach (start_log[i]) if (start_log[i].c == drop_cyc) di = i;
        wait_starts(di + 2, 400, "restart_after_timeout");
        if (start_log.size() > di + 1) chk("restart_reg", start_log[di + 1].rg, 8'h41);
        wait_sv(sv_cnt + 1, 600, "salted_publish");
        rd_chk(7, 8'hB7, "salted_readout");

        // en dropped mid-read
        tick();
        salt = 8'h20;
        wait_reg(8'h44, 400, "reach_reg44");
        tick(); tick();
        en = 1'b0;
        ns = start_log.size();
        nd = done_log.size();
        n = 0;
        while (done_log.size() == nd && n < 40) begin nwait(); n++; end
        chk("done_after_stop", (n < 40), 1);
        nwait(); nwait();
        chk("busy_after_stop", busy, 0);
        repeat (300) nwait();
        chk("no_start_after_stop", start_log.size(), ns);
        rd_chk(0, 8'hB0, "snapshot_kept_after_stop");

        // Resume keeps init_done, then reset mid-read
        tick();
        en = 1'b1;
        wait_starts(ns + 1, 50, "resume_start");
        if (start_log.size() > ns) chk("resume_reg", start_log[ns].rg, 8'h41);
        wait_reg(8'h42, 100, "reach_reg42");
        tick(); tick();
        rst = 1'b0; en = 1'b0;
        @(posedge clk);
        nwait();
        chk("mid_rst_start", bus.i2c_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", sweep_count, 0);
        chk("mid_rst_terr", timeout_err, 0);
        chk("mid_rst_reg", bus.ext_register_address_in, 0);
        chk("mid_rst_rw", bus.ext_read_write_in, 0);
        tick();
        rst = 1'b1;
        ns = start_log.size();
        rd_chk(0, 8'h00, "snapshot_cleared0");
        rd_chk(3, 8'h00, "snapshot_cleared3");
        repeat (60) nwait();
        chk("no_start_while_disabled", start_log.size(), ns);
        tick();
        en = 1'b1;
        wait_starts(ns + 1, 50, "reinit_start");
        if (start_log.size() > ns) begin
            chk("reinit_rw", start_log[ns].rw, 0);
            chk("reinit_reg", start_log[ns].rg, 8'h6B);
        end
        wait_sv(sv_cnt + 1, 600, "publish_after_reset");
        nwait();
        chk("count_after_reset", sweep_count, 1);
        rd_chk(2, 8'hC2, "readout_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
